// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared types and constants for the instruction fetch stage
package instr_fetch_pkg;

    localparam int FETCH_W = 16;
    localparam logic [FETCH_W-1:0] NOP = 16'h0000;

    typedef struct packed {
        logic [FETCH_W-1:0] pc;
        logic [FETCH_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_fifo.sv
// rtl/instr_fetch_fifo.sv - prefetch FIFO holding {pc, instr} entries with flush
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch PC, imem request handshake, prefetch buffering, redirect/halt
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] alt_pc,
    input  logic        alt_pc_ctrl,
    input  logic        hlt,
    input  logic        stall,
    input  logic [15:0] imem_rdata,
    input  logic        imem_rdy,
    output logic        imem_re,
    output logic [15:0] imem_addr,
    output logic [15:0] instr,
    output logic [15:0] pc,
    output logic        instr_vld,
    output logic        halted
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  state_q;
    fetch_state_t  state_d;
    logic [15:0]   fpc;
    logic [CW-1:0] count;
    fetch_entry_t  head;
    fetch_entry_t  push_data;
    logic          fifo_empty;
    logic          consume;
    logic          halt_now;
    logic          redirect;
    logic          flush;
    logic          accept;

    assign fifo_empty = (count == '0);
    assign consume    = instr_vld && !stall;
    assign halt_now   = consume && hlt;
    assign redirect   = consume && alt_pc_ctrl && !hlt;
    assign flush      = halt_now || redirect;

    // A flushing cycle drops the request so wrong-path data is never pushed.
    assign imem_re   = rst_n && (state_q == RUN) && (count < CW'(FIFO_DEPTH)) && !flush;
    assign imem_addr = fpc;
    assign accept    = imem_re && imem_rdy;
    assign push_data = '{pc: fpc, instr: imem_rdata};

    assign instr_vld = !fifo_empty;
    assign instr     = fifo_empty ? NOP : head.instr;
    assign pc        = fifo_empty ? fpc : head.pc;
    assign halted    = (state_q == HALTED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (halt_now) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc <= RESET_PC;
        end else if (redirect) begin
            fpc <= alt_pc;
        end else if (accept) begin
            fpc <= fpc + 16'd1;
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (accept),
        .push_data (push_data),
        .pop       (consume),
        .head      (head),
        .count     (count)
    );

endmodule
